// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg
// Shared constants for the iterative multiply/divide unit: operation codes
// issued by the control unit and the FSM state encoding.
package mips_muldiv_pkg;

    // Operation codes (3-bit op port). Codes 6 and 7 are accepted but ignored.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // True for the opcodes whose operands are interpreted as two's complement.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_abs_neg.sv
// muldiv_abs_neg
// Combinational two's-complement conditional negate. Used both to take the
// magnitude of a signed operand (negate_i = sign bit) and to restore the
// sign of a result after the unsigned iteration.
// Ports:
//   value_i  [DATA_WIDTH-1:0]  input value
//   negate_i                   1 = output -value_i, 0 = pass through
//   result_o [DATA_WIDTH-1:0]  conditionally negated value
module muldiv_abs_neg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic                  negate_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    // The most-negative value negates to itself, which is exactly its
    // unsigned magnitude, so no special case is needed.
    assign result_o = negate_i ? (~value_i + {{(DATA_WIDTH-1){1'b0}}, 1'b1})
                               : value_i;

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
// Iterative multiply/divide unit with HI/LO registers. MULT/MULTU use one
// shift-add step per cycle, DIV/DIVU one restoring shift-subtract step per
// cycle, both on operand magnitudes; a final FIX cycle restores signs and
// writes HI/LO. MTHI/MTLO write HI/LO directly from rs_data.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, op             issue request and operation code (sampled in IDLE)
//   rs_data, rt_data      operands / MTHI-MTLO source
//   busy                  iteration in progress (upstream stalls)
//   done, div_by_zero     one-cycle result pulses
//   hi, lo                HI/LO architectural registers
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int DW      = DATA_WIDTH;
    localparam int COUNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(DATA_WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]      acc_q, acc_d;      // product high half / partial remainder
    logic [DW-1:0]      mq_q, mq_d;        // multiplier -> product low / dividend -> quotient
    logic [DW-1:0]      mcand_q, mcand_d;  // multiplicand / divisor magnitude
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               is_div_q, is_div_d;
    logic [DW-1:0]      hi_q, hi_d;
    logic [DW-1:0]      lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               rs_neg_s, rt_neg_s;
    logic [DW-1:0]      rs_mag_s, rt_mag_s;
    logic [2*DW-1:0]    prod_fix_s;
    logic [DW-1:0]      quo_fix_s, rem_fix_s;
    logic [DW:0]        mul_sum_s;
    logic [DW:0]        div_shift_s, div_diff_s;

    assign rs_neg_s = is_signed_op(op) && rs_data[DW-1];
    assign rt_neg_s = is_signed_op(op) && rt_data[DW-1];

    muldiv_abs_neg #(.DATA_WIDTH(DW)) u_rs_abs (
        .value_i(rs_data), .negate_i(rs_neg_s), .result_o(rs_mag_s));
    muldiv_abs_neg #(.DATA_WIDTH(DW)) u_rt_abs (
        .value_i(rt_data), .negate_i(rt_neg_s), .result_o(rt_mag_s));
    muldiv_abs_neg #(.DATA_WIDTH(2*DW)) u_prod_fix (
        .value_i({acc_q, mq_q}), .negate_i(neg_lo_q), .result_o(prod_fix_s));
    muldiv_abs_neg #(.DATA_WIDTH(DW)) u_quo_fix (
        .value_i(mq_q), .negate_i(neg_lo_q), .result_o(quo_fix_s));
    muldiv_abs_neg #(.DATA_WIDTH(DW)) u_rem_fix (
        .value_i(acc_q), .negate_i(neg_hi_q), .result_o(rem_fix_s));

    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift {acc, mq} right by one with the carry entering at the top.
    assign mul_sum_s   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(DW+1){1'b0}});
    // Restoring divide: shift next dividend bit into the remainder and try
    // to subtract; bit DW of the difference set means "restore".
    assign div_shift_s = {acc_q, mq_q[DW-1]};
    assign div_diff_s  = div_shift_s - {1'b0, mcand_q};

    // Next-state logic for the FSM, datapath and HI/LO.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        mcand_d  = mcand_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d  = ST_MUL;
                            cnt_d    = {COUNT_W{1'b0}};
                            acc_d    = {DW{1'b0}};
                            mq_d     = rt_mag_s;
                            mcand_d  = rs_mag_s;
                            neg_lo_d = rs_neg_s ^ rt_neg_s;
                            neg_hi_d = 1'b0;
                            is_div_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (rt_data == {DW{1'b0}}) begin
                                hi_d   = rs_data;
                                lo_d   = {DW{1'b1}};
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                state_d  = ST_DIV;
                                cnt_d    = {COUNT_W{1'b0}};
                                acc_d    = {DW{1'b0}};
                                mq_d     = rs_mag_s;
                                mcand_d  = rt_mag_s;
                                neg_lo_d = rs_neg_s ^ rt_neg_s;
                                neg_hi_d = rs_neg_s;  // remainder follows dividend
                                is_div_d = 1'b1;
                            end
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;  // undefined ops: accepted, no effect
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d = mul_sum_s[DW:1];
                mq_d  = {mul_sum_s[0], mq_q[DW-1:1]};
                cnt_d = cnt_q + COUNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DIV: begin
                if (!div_diff_s[DW]) begin
                    acc_d = div_diff_s[DW-1:0];
                    mq_d  = {mq_q[DW-2:0], 1'b1};
                end else begin
                    acc_d = div_shift_s[DW-1:0];
                    mq_d  = {mq_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q + COUNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*DW-1:DW];
                    lo_d = prod_fix_s[DW-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {COUNT_W{1'b0}};
            acc_q    <= {DW{1'b0}};
            mq_q     <= {DW{1'b0}};
            mcand_q  <= {DW{1'b0}};
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= {DW{1'b0}};
            lo_q     <= {DW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            mcand_q  <= mcand_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
// Directed, table-driven bench for mips_muldiv_unit (DATA_WIDTH=32) plus
// hand-written sequences for MTHI/MTLO, ignored start, back-to-back issue,
// undefined ops and mid-operation reset. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starting at cycle n0 after acceptance, step until done (bounded).
    task automatic wait_done(input int n0, output int n, output int bc, output bit got);
        n = n0; bc = 0; got = 1'b0;
        while (!got && n <= 80) begin
            if (busy) bc++;
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen within 80 cycles");
        end
    endtask

    int  n, bc;
    bit  got;

    initial begin
        // op, rs, rt, hi, lo, dbz
        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
        vecs[4]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        vecs[10] = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[11] = '{3'd2, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};

        reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_dbz", div_by_zero, 1'b0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            rs_data = 32'hA5A5A5A5; rt_data = 32'h5A5A5A5A;  // must not be re-sampled
            wait_done(1, n, bc, got);
            if (got) begin
                chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
                chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
                chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].exp_dbz);
                chk($sformatf("v%0d_done_cycle", i), n, vecs[i].exp_dbz ? 1 : 34);
                chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_dbz ? 0 : 33);
                chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
                @(negedge clk);
                chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
                chk($sformatf("v%0d_dbz_pulse", i), div_by_zero, 1'b0);
            end
        end

        // MTHI / MTLO: visible next cycle, no busy/done.
        issue(3'd4, 32'h0000CAFE, 32'h0);
        chk("mthi_hi", hi, 32'h0000CAFE);
        chk("mthi_busy", busy, 1'b0);
        chk("mthi_done", done, 1'b0);
        issue(3'd5, 32'h0000BEEF, 32'h0);
        chk("mtlo_lo", lo, 32'h0000BEEF);
        chk("mtlo_hi_kept", hi, 32'h0000CAFE);
        chk("mtlo_done", done, 1'b0);

        // Undefined op: nothing changes.
        issue(3'd6, 32'h11111111, 32'h22222222);
        chk("undef_hi", hi, 32'h0000CAFE);
        chk("undef_lo", lo, 32'h0000BEEF);
        chk("undef_busy", busy, 1'b0);
        chk("undef_done", done, 1'b0);

        // MULTU 5x6 with an ignored DIVU issued while busy; hi/lo held meanwhile.
        issue(3'd1, 32'd5, 32'd6);
        repeat (4) @(negedge clk);                   // now cycle 5
        chk("hold_hi", hi, 32'h0000CAFE);
        chk("hold_lo", lo, 32'h0000BEEF);
        issue(3'd3, 32'd9, 32'd3);                   // now cycle 6
        wait_done(6, n, bc, got);
        if (got) begin
            chk("ignored_start_hi", hi, 32'd0);
            chk("ignored_start_lo", lo, 32'd30);
            chk("ignored_start_cycle", n, 34);
            // Back-to-back issue in the done cycle.
            issue(3'd1, 32'd2, 32'd3);
            chk("b2b_busy", busy, 1'b1);
            chk("b2b_done_low", done, 1'b0);
            wait_done(1, n, bc, got);
            if (got) begin
                chk("b2b_lo", lo, 32'd6);
                chk("b2b_cycle", n, 34);
            end
        end

        // Reset during iteration 10 of a DIV.
        @(negedge clk);
        issue(3'd2, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        repeat (40) @(negedge clk);
        chk("rst_no_late_done", done, 1'b0);
        // Unit must be idle and accept a fresh operation.
        issue(3'd3, 32'd7, 32'd2);
        wait_done(1, n, bc, got);
        if (got) begin
            chk("post_rst_lo", lo, 32'd3);
            chk("post_rst_hi", hi, 32'd1);
            chk("post_rst_cycle", n, 34);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
